// File: rtl/line_fill_responder_pkg.sv
// Shared constants and state type for the line fill responder.
package line_fill_responder_pkg;

    localparam int LINE_WORDS = 16;
    localparam int LINE_BITS  = 512;
    localparam int WORD_BITS  = 32;
    localparam int LINE_OFF_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/line_fill_responder_mem_word_array.sv
// Word-addressed backing array: one 32-bit write port, one aligned 16-word line read port.
// Contents are not reset, so they survive a responder reset.
module mem_word_array
    import line_fill_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [WORD_BITS-1:0]     wdata_i,
    input  logic [AW-LINE_OFF_W-1:0] rline_i,
    output logic [LINE_BITS-1:0]     rdata_o
);

    logic [WORD_BITS-1:0] mem_q [DEPTH_WORDS];

    // Single-word write, no reset on the storage.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational line read; word k of the line lands at bits [32k+31:32k].
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            rdata_o[k*WORD_BITS +: WORD_BITS] = mem_q[{rline_i, LINE_OFF_W'(k)}];
        end
    end

endmodule

// File: rtl/line_fill_responder.sv
// Backing-store responder for the d-cache refill path: one request at a time,
// either a 64-byte line read or a single-word write, answered LATENCY cycles
// after acceptance.
// Optional macro DMEM_ERR_EN: flag out-of-range addresses with resp_err_o,
// suppress the write and return a zero line; otherwise addresses wrap.
//
// state | meaning
// IDLE  | ready for a request; accepting edge writes the array for writes
// WAIT  | latency down-counter running, terminal count at zero
// RESP  | response registered and held until resp_ready_i
module line_fill_responder
    import line_fill_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_write_o,
    output logic [LINE_BITS-1:0] resp_line_o,
    output logic                 resp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e               state_q;
    logic [7:0]           cnt_q;
    logic [AW-1:0]        widx_q;
    logic                 write_q;
    logic                 err_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic                 resp_write_q;
    logic                 resp_err_q;
    logic [LINE_BITS-1:0] resp_line_q;

    logic                 accept;
    logic                 req_oor;
    logic                 mem_we;
    logic [LINE_BITS-1:0] rd_line;
    logic                 unused_addr;

    assign accept = (state_q == IDLE) && req_valid_i;

`ifdef DMEM_ERR_EN
    assign req_oor = |req_addr_i[31:AW+2];
`else
    assign req_oor = 1'b0;
`endif

    // Byte-offset bits never matter; upper bits only matter for the range check.
    assign unused_addr = ^{req_addr_i[1:0], req_addr_i[31:AW+2]};

    // Writes commit at the accepting edge so a later read sees them immediately.
    assign mem_we = accept && req_write_i && !req_oor;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .waddr_i(req_addr_i[AW+1:2]),
        .wdata_i(req_wdata_i),
        .rline_i(widx_q[AW-1:LINE_OFF_W]),
        .rdata_o(rd_line)
    );

    // Request/latency/response sequencer with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            widx_q       <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_line_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q     <= WAIT;
                        cnt_q       <= 8'(LATENCY - 1);
                        widx_q      <= req_addr_i[AW+1:2];
                        write_q     <= req_write_i;
                        err_q       <= req_oor;
                        req_ready_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_write_q <= write_q;
                        resp_err_q   <= err_q;
                        resp_line_q  <= (write_q || err_q) ? '0 : rd_line;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP: begin
                    // A request arriving alongside the handshake waits for IDLE.
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_write_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_line_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_write_o = resp_write_q;
    assign resp_line_o  = resp_line_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: two instances (LATENCY 8 and 1) with a
// reference word model and an expected-response queue.
`timescale 1ns/1ps
module tb_line_fill_responder;

    localparam int DEPTH = 1024;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          sel;
        bit          wr;
        logic [511:0] line;
        bit          err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_ready [2];

    logic         req_ready0, resp_valid0, resp_write0, resp_err0;
    logic [511:0] resp_line0;
    logic         req_ready1, resp_valid1, resp_write1, resp_err1;
    logic [511:0] resp_line1;

    logic [31:0] model [2][DEPTH];
    exp_t        sb_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_fill_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(8)) u_dut_l8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready0),
        .req_write_i (req_write[0]),
        .req_addr_i  (req_addr[0]),
        .req_wdata_i (req_wdata[0]),
        .resp_valid_o(resp_valid0),
        .resp_ready_i(resp_ready[0]),
        .resp_write_o(resp_write0),
        .resp_line_o (resp_line0),
        .resp_err_o  (resp_err0)
    );

    line_fill_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready1),
        .req_write_i (req_write[1]),
        .req_addr_i  (req_addr[1]),
        .req_wdata_i (req_wdata[1]),
        .resp_valid_o(resp_valid1),
        .resp_ready_i(resp_ready[1]),
        .resp_write_o(resp_write1),
        .resp_line_o (resp_line1),
        .resp_err_o  (resp_err1)
    );

    function automatic logic f_rr(input int s); return (s != 0) ? req_ready1  : req_ready0;  endfunction
    function automatic logic f_rv(input int s); return (s != 0) ? resp_valid1 : resp_valid0; endfunction
    function automatic logic f_rw(input int s); return (s != 0) ? resp_write1 : resp_write0; endfunction
    function automatic logic f_re(input int s); return (s != 0) ? resp_err1   : resp_err0;   endfunction
    function automatic logic [511:0] f_rl(input int s); return (s != 0) ? resp_line1 : resp_line0; endfunction
    function automatic int f_lat(input int s); return (s != 0) ? 1 : 8; endfunction

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply the request to the reference model and queue the response it should produce.
    task automatic sb_push(input int sel, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int acc);
        exp_t        e;
        logic [29:0] widx;
        int          idx, base;
        bit          oor;
        widx   = addr[31:2];
        oor    = (widx >= 30'(DEPTH));
        idx    = int'(widx % 30'(DEPTH));
        base   = idx & ~15;
        e.sel  = sel;
        e.wr   = wr;
        e.acc  = acc;
        e.err  = ERR_EN && oor;
        e.line = '0;
        if (wr) begin
            if (!e.err) model[sel][idx] = wd;
        end else if (!e.err) begin
            for (int k = 0; k < 16; k++) e.line[32*k +: 32] = model[sel][base+k];
        end
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input int sel);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_nonempty", 512'(sb_q.size()), 512'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq("latency", 512'(cyc - e.acc), 512'(f_lat(sel)));
        check_eq("resp_valid", f_rv(sel), 1'b1);
        check_eq("resp_write", f_rw(sel), e.wr);
        check_eq("resp_line", f_rl(sel), e.line);
        check_eq("resp_err", f_re(sel), e.err);
    endtask

    // One full transaction; optionally stall RESP for `hold` cycles and poke a write meanwhile.
    task automatic do_req(input int sel, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, input bit poke);
        int           acc;
        int           waited;
        logic [511:0] line_s;
        @(negedge clk);
        check_eq("ready_idle", f_rr(sel), 1'b1);
        req_valid[sel] = 1'b1;
        req_write[sel] = wr;
        req_addr[sel]  = addr;
        req_wdata[sel] = wd;
        @(negedge clk);
        acc = cyc;
        sb_push(sel, wr, addr, wd, acc);
        req_valid[sel] = 1'b0;
        check_eq("ready_drop", f_rr(sel), 1'b0);
        waited = 0;
        while (!f_rv(sel) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!f_rv(sel)) begin
            check_eq("resp_timeout", f_rv(sel), 1'b1);
            return;
        end
        sb_pop_check(sel);
        line_s = f_rl(sel);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                req_valid[sel] = 1'b1;
                req_write[sel] = 1'b1;
                req_addr[sel]  = 32'h48;
                req_wdata[sel] = 32'h0BAD_F00D;
            end
            @(negedge clk);
            check_eq("hold_valid", f_rv(sel), 1'b1);
            check_eq("hold_line", f_rl(sel), line_s);
            check_eq("hold_ready", f_rr(sel), 1'b0);
        end
        req_valid[sel]  = 1'b0;
        req_write[sel]  = 1'b0;
        resp_ready[sel] = 1'b1;
        @(negedge clk);
        resp_ready[sel] = 1'b0;
        check_eq("post_valid", f_rv(sel), 1'b0);
        check_eq("post_ready", f_rr(sel), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        bit  seen;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_write[s]  = 1'b0;
            req_addr[s]   = '0;
            req_wdata[s]  = '0;
            resp_ready[s] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_ready", f_rr(s), 1'b1);
            check_eq("rst_valid", f_rv(s), 1'b0);
            check_eq("rst_write", f_rw(s), 1'b0);
            check_eq("rst_line", f_rl(s), 512'd0);
            check_eq("rst_err", f_re(s), 1'b0);
        end
        rst_n = 1'b1;

        // Known contents for lines 0 and 1 of both instances.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                do_req(s, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(s << 24) + 32'(i * 32'h111), 0, 1'b0);

        do_req(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 0, 1'b0);
        do_req(0, 1'b0, 32'h44, 32'h0, 0, 1'b0);
        do_req(0, 1'b0, 32'h44, 32'h0, 5, 1'b1);
        do_req(0, 1'b0, 32'h40, 32'h0, 0, 1'b0);

        // Back-to-back on LATENCY=1 with req_valid held through the handshake.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h0;
        @(negedge clk);
        acc = cyc;
        sb_push(1, 1'b0, 32'h0, 32'h0, acc);
        req_addr[1] = 32'h40;
        check_eq("b2b_ready_drop", f_rr(1), 1'b0);
        @(negedge clk);
        sb_pop_check(1);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        check_eq("b2b_idle_valid", f_rv(1), 1'b0);
        check_eq("b2b_idle_ready", f_rr(1), 1'b1);
        @(negedge clk);
        acc = cyc;
        sb_push(1, 1'b0, 32'h40, 32'h0, acc);
        req_valid[1] = 1'b0;
        check_eq("b2b_second_accept", f_rr(1), 1'b0);
        @(negedge clk);
        sb_pop_check(1);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        check_eq("b2b_post_valid", f_rv(1), 1'b0);

        // Reset in the middle of WAIT drops the pending read.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h40;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", f_rv(0), 1'b0);
        check_eq("midrst_ready", f_rr(0), 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | f_rv(0);
        end
        check_eq("midrst_no_resp", seen, 1'b0);
        do_req(0, 1'b0, 32'h40, 32'h0, 0, 1'b0);

        // Out-of-range write: flagged with the error option, aliases to word 0 otherwise.
        do_req(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 0, 1'b0);
        do_req(0, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        for (int n = 0; n < 10; n++)
            do_req(1, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)),
                   32'($urandom), 0, 1'b0);

        check_eq("sb_drained", 512'(sb_q.size()), 512'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
Backing-store responder on the data-cache refill interface. It accepts one request at a time from the d-cache miss handler: either a 64-byte line read or a single 32-bit word write. After a fixed programmable latency it returns either the full 512-bit line or a write acknowledge. It sits below the cache in the memory stage, and its busy/response timing drives the pipeline's stallM.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, multiple of 16)
LATENCY, 8, cycles from request acceptance to resp_valid (legal range 1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = word write, 0 = line read
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  write data
resp_valid  output  1  response available
resp_ready  input  1  requester consumes response
resp_write  output  1  response is a write acknowledge (echoes req_write)
resp_line  output  512  read line; word k at bits [32k+31:32k]
resp_err  output  1  address out of range (only with DMEM_ERR_EN, else tied 0)

Behaviour:
- Reset (rst low, async): state IDLE; req_ready=1, resp_valid=0, resp_write=0, resp_line=0, resp_err=0, counter=0. The array is not cleared and contents are retained across reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge and the FSM goes to WAIT with counter=LATENCY-1. Address, write flag and data are latched.
  - WAIT: req_ready=0. Counter decrements each cycle. When the counter reaches 0, the FSM goes to RESP.
  - RESP: resp_valid=1, and outputs are held stable until resp_ready. On resp_valid&&resp_ready, the FSM goes to IDLE and resp_valid drops the next cycle.
- Latency: resp_valid rises exactly LATENCY cycles after the accepting edge.
  - LATENCY=1: accept at edge N, resp_valid high after edge N+1.
- Back-to-back: req_ready is 0 in WAIT and RESP. Requests in those states are ignored, not queued. A new request is only accepted from IDLE, so throughput is at most one request per LATENCY+2 cycles.
- Word index = req_addr[31:2] modulo DEPTH_WORDS. Line base = word index with its low 4 bits cleared.
- Writes:
  - The array is updated at the accepting edge.
  - resp_line=0 for a write acknowledge.
  - A read accepted later returns the new data.
- Reads: the line is sampled from the array in the cycle the FSM enters RESP.
- Simultaneous resp_ready and req_valid in RESP: the response completes, and the new request is not accepted until the IDLE cycle.
- Reset mid-WAIT or mid-RESP: the pending response is dropped and the FSM returns to IDLE. A write already committed to the array stays committed.

Optional Feature:
DMEM_ERR_EN
- Defined: a request with req_addr[31:2] >= DEPTH_WORDS sets resp_err=1 in RESP.
  - Writes are suppressed.
  - Reads return resp_line=0.
  - Latency is unchanged.
- Undefined: resp_err is tied 0 and addresses wrap modulo DEPTH_WORDS.

Decomposition:
- Shared package holds:
  - LINE_WORDS=16, LINE_BITS=512, WORD_BITS=32
  - the state enum {IDLE, WAIT, RESP}
  - the line-offset width constant (4)
- One natural sub-module, mem_word_array: a DEPTH_WORDS x 32 array with a single-word write port and a 16-word aligned line read port. The FSM and counter stay in the top.

Test Plan:
- Reset, then a write of 0xDEADBEEF to addr 0x40 (LATENCY=8) -> req_ready drops after the accept edge; resp_valid with resp_write=1 exactly 8 cycles later; resp_line=0.
- Read addr 0x44 after that write -> resp_line word 0 = 0xDEADBEEF (line base 0x40); other words hold their previously written values.
- Hold resp_ready=0 for 5 cycles during RESP -> resp_valid and resp_line stay stable; a req_valid pulse in that window is ignored; IDLE follows the handshake.
- LATENCY=1, back-to-back reads at 0x0 and 0x40 -> each resp_valid follows its accept by 1 cycle; the second accept occurs only in the IDLE cycle after the first handshake.
- Assert rst low during WAIT of a read -> resp_valid never rises, req_ready=1 immediately; a read issued after reset returns correct data.
- With DMEM_ERR_EN, DEPTH_WORDS=1024, write to 0x1000 -> resp_err=1, and a subsequent read of 0x0 shows word 0 unchanged. Without the macro, the same write aliases to word 0.
